// File: rtl/radar_sweep_scheduler.sv
// Radar sweep sequencer: ping-pongs the servo angle, waits for settling, triggers one ranging
// cycle per angle and emits an (angle, distance) sample on a valid/ready stream.
module radar_sweep_scheduler #(
   parameter int unsigned ANGLE_W     = 8,
   parameter int unsigned DIST_W      = 10,
   parameter int unsigned ANGLE_MAX   = 180,
   parameter int unsigned ANGLE_STEP  = 1,
   parameter int unsigned SETTLE_CYC  = 1_000_000,
   parameter int unsigned TIMEOUT_CYC = 1_900_000
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic               enable,
   output logic [ANGLE_W-1:0] servo_angle,
   output logic               sweep_dir,
   output logic               meas_start,
   input  logic               meas_done,
   input  logic [DIST_W-1:0]  meas_dist,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic [ANGLE_W-1:0] sample_angle,
   output logic [DIST_W-1:0]  sample_dist,
   output logic               sample_timeout,
   output logic               busy
);

   localparam int unsigned CntMax = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0]    SettleLast  = CntW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0]    TimeoutLast = CntW'(TIMEOUT_CYC - 1);
   localparam logic [ANGLE_W-1:0] AngleMax    = ANGLE_W'(ANGLE_MAX);
   localparam logic [ANGLE_W-1:0] AngleStep   = ANGLE_W'(ANGLE_STEP);

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StTrig,
      StWait,
      StOut,
      StStep
   } state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic               dir_q, dir_d;
   logic               start_q, start_d;
   logic               valid_q, valid_d;
   logic [ANGLE_W-1:0] sangle_q, sangle_d;
   logic [DIST_W-1:0]  sdist_q, sdist_d;
   logic               stimeout_q, stimeout_d;
   logic               busy_q, busy_d;

   // Next-state and registered-output logic. Outputs are derived from state_d so that each
   // registered output lines up with the state it belongs to.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      angle_d    = angle_q;
      dir_d      = dir_q;
      valid_d    = valid_q;
      sangle_d   = sangle_q;
      sdist_d    = sdist_q;
      stimeout_d = stimeout_q;

      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StSettle;
               cnt_d   = '0;
            end
         end

         StSettle: begin
            if (cnt_q == SettleLast) begin
               state_d = StTrig;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StTrig: begin
            state_d = StWait;
            cnt_d   = '0;
         end

         StWait: begin
            // An echo arriving on the last timeout cycle still counts as a hit.
            if (meas_done) begin
               state_d    = StOut;
               valid_d    = 1'b1;
               sangle_d   = angle_q;
               sdist_d    = meas_dist;
               stimeout_d = 1'b0;
            end else if (cnt_q == TimeoutLast) begin
               state_d    = StOut;
               valid_d    = 1'b1;
               sangle_d   = angle_q;
               sdist_d    = {DIST_W{1'b1}};
               stimeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StOut: begin
            if (valid_q && sample_ready) begin
               state_d = StStep;
               valid_d = 1'b0;
            end
         end

         StStep: begin
            // Endpoints reverse direction and step back inward in the same update.
            if (dir_q) begin
               if (angle_q == AngleMax) begin
                  dir_d   = 1'b0;
                  angle_d = angle_q - AngleStep;
               end else begin
                  angle_d = angle_q + AngleStep;
               end
            end else begin
               if (angle_q == '0) begin
                  dir_d   = 1'b1;
                  angle_d = angle_q + AngleStep;
               end else begin
                  angle_d = angle_q - AngleStep;
               end
            end
            cnt_d   = '0;
            state_d = enable ? StSettle : StIdle;
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase

      start_d = (state_d == StTrig);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         angle_q    <= '0;
         dir_q      <= 1'b1;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
         sangle_q   <= '0;
         sdist_q    <= '0;
         stimeout_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         angle_q    <= angle_d;
         dir_q      <= dir_d;
         start_q    <= start_d;
         valid_q    <= valid_d;
         sangle_q   <= sangle_d;
         sdist_q    <= sdist_d;
         stimeout_q <= stimeout_d;
         busy_q     <= busy_d;
      end
   end

   assign servo_angle    = angle_q;
   assign sweep_dir      = dir_q;
   assign meas_start     = start_q;
   assign sample_valid   = valid_q;
   assign sample_angle   = sangle_q;
   assign sample_dist    = sdist_q;
   assign sample_timeout = stimeout_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_radar_sweep_scheduler.sv
// Directed bench for radar_sweep_scheduler with SETTLE_CYC=4, TIMEOUT_CYC=10, ANGLE_MAX=4,
// ANGLE_STEP=2. Inputs are driven and outputs sampled on the falling clock edge.
module tb_radar_sweep_scheduler;

   logic       clk_clk = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] servo_angle;
   logic       sweep_dir;
   logic       meas_start;
   logic       meas_done = 1'b0;
   logic [9:0] meas_dist = '0;
   logic       sample_valid;
   logic       sample_ready = 1'b0;
   logic [7:0] sample_angle;
   logic [9:0] sample_dist;
   logic       sample_timeout;
   logic       busy;

   int total = 0;
   int bad   = 0;

   always #5 clk_clk = ~clk_clk;

   radar_sweep_scheduler #(
      .ANGLE_W    (8),
      .DIST_W     (10),
      .ANGLE_MAX  (4),
      .ANGLE_STEP (2),
      .SETTLE_CYC (4),
      .TIMEOUT_CYC(10)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .enable        (enable),
      .servo_angle   (servo_angle),
      .sweep_dir     (sweep_dir),
      .meas_start    (meas_start),
      .meas_done     (meas_done),
      .meas_dist     (meas_dist),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .sample_angle  (sample_angle),
      .sample_dist   (sample_dist),
      .sample_timeout(sample_timeout),
      .busy          (busy)
   );

   // Advances falling edges until meas_start is seen or the budget runs out.
   task automatic wait_meas_start(output bit found);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_clk);
         if (meas_start === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk_clk);
      @(negedge clk_clk);
      total++;
      if ({busy, meas_start, sample_valid, sample_timeout} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0000",
                  {busy, meas_start, sample_valid, sample_timeout});
      end
      total++;
      if (servo_angle !== 8'd0 || sweep_dir !== 1'b1) begin
         bad++;
         $display("FAIL reset_angle: got angle=%0d dir=%b want angle=0 dir=1",
                  servo_angle, sweep_dir);
      end
      total++;
      if (sample_angle !== 8'd0 || sample_dist !== 10'd0) begin
         bad++;
         $display("FAIL reset_sample: got angle=%0d dist=%0d want 0 0", sample_angle, sample_dist);
      end
      reset_reset_n = 1'b1;
   endtask

   // enable seen at edge 0; falling edge k shows cycle k. meas_start only in cycle 5.
   task automatic test_start_latency;
      enable       = 1'b1;
      sample_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_clk);
         total++;
         if (meas_start !== (k == 5)) begin
            bad++;
            $display("FAIL start_latency cycle %0d: got meas_start=%b want %b",
                     k, meas_start, (k == 5));
         end
         if (k == 1) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL busy_after_enable: got %b want 1", busy);
            end
         end
      end
      total++;
      if (servo_angle !== 8'd0 || sweep_dir !== 1'b1) begin
         bad++;
         $display("FAIL first_angle: got angle=%0d dir=%b want 0 1", servo_angle, sweep_dir);
      end
   endtask

   task automatic test_capture;
      @(negedge clk_clk);
      @(negedge clk_clk);
      @(negedge clk_clk);
      total++;
      if (sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL capture_early_valid: got %b want 0", sample_valid);
      end
      meas_done = 1'b1;
      meas_dist = 10'd123;
      @(negedge clk_clk);
      meas_done = 1'b0;
      total++;
      if (sample_valid !== 1'b1 || sample_angle !== 8'd0 || sample_dist !== 10'd123 ||
          sample_timeout !== 1'b0) begin
         bad++;
         $display("FAIL capture_sample: got v=%b a=%0d d=%0d t=%b want v=1 a=0 d=123 t=0",
                  sample_valid, sample_angle, sample_dist, sample_timeout);
      end
      @(negedge clk_clk);
      total++;
      if (sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL capture_valid_drop: got %b want 0", sample_valid);
      end
      @(negedge clk_clk);
      total++;
      if (servo_angle !== 8'd2 || sweep_dir !== 1'b1) begin
         bad++;
         $display("FAIL capture_step: got angle=%0d dir=%b want 2 1", servo_angle, sweep_dir);
      end
   endtask

   task automatic test_timeout;
      bit found;
      wait_meas_start(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL timeout_start: got no meas_start want one");
      end
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk_clk);
         total++;
         if (sample_valid !== (k == 11)) begin
            bad++;
            $display("FAIL timeout_valid cycle %0d: got %b want %b", k, sample_valid, (k == 11));
         end
      end
      total++;
      if (sample_dist !== 10'd1023 || sample_timeout !== 1'b1 || sample_angle !== 8'd2) begin
         bad++;
         $display("FAIL timeout_sample: got d=%0d t=%b a=%0d want d=1023 t=1 a=2",
                  sample_dist, sample_timeout, sample_angle);
      end
   endtask

   task automatic test_backpressure;
      bit found;
      bit held;
      wait_meas_start(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL bp_start: got no meas_start want one");
      end
      sample_ready = 1'b0;
      @(negedge clk_clk);
      meas_done = 1'b1;
      meas_dist = 10'd77;
      @(negedge clk_clk);
      meas_done = 1'b0;
      held = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (sample_valid !== 1'b1 || sample_dist !== 10'd77 || sample_angle !== 8'd4 ||
             sample_timeout !== 1'b0 || meas_start !== 1'b0)
            held = 1'b0;
         @(negedge clk_clk);
      end
      total++;
      if (!held) begin
         bad++;
         $display("FAIL bp_hold: got unstable sample v=%b a=%0d d=%0d want v=1 a=4 d=77",
                  sample_valid, sample_angle, sample_dist);
      end
      sample_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_clk);
         if (k == 1) begin
            total++;
            if (sample_valid !== 1'b0) begin
               bad++;
               $display("FAIL bp_valid_drop: got %b want 0", sample_valid);
            end
         end
         if (k == 2) begin
            total++;
            if (servo_angle !== 8'd2 || sweep_dir !== 1'b0) begin
               bad++;
               $display("FAIL bp_turn: got angle=%0d dir=%b want 2 0", servo_angle, sweep_dir);
            end
         end
         total++;
         if (meas_start !== (k == 6)) begin
            bad++;
            $display("FAIL bp_restart cycle %0d: got %b want %b", k, meas_start, (k == 6));
         end
      end
   endtask

   task automatic test_sweep;
      logic [7:0] exp_angle [6] = '{8'd0, 8'd2, 8'd4, 8'd2, 8'd0, 8'd2};
      logic       exp_dir   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      bit found;
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_meas_start(found);
         @(negedge clk_clk);
         meas_done = 1'b1;
         meas_dist = 10'(100 + i);
         @(negedge clk_clk);
         meas_done = 1'b0;
         total++;
         if (!found || sample_valid !== 1'b1 || sample_angle !== exp_angle[i] ||
             sweep_dir !== exp_dir[i] || sample_dist !== 10'(100 + i)) begin
            bad++;
            $display("FAIL sweep sample %0d: got v=%b a=%0d dir=%b d=%0d want v=1 a=%0d dir=%b d=%0d",
                     i, sample_valid, sample_angle, sweep_dir, sample_dist, exp_angle[i],
                     exp_dir[i], 100 + i);
         end
      end
   endtask

   task automatic test_reset_mid_wait;
      bit found;
      bit quiet;
      wait_meas_start(found);
      @(negedge clk_clk);
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      enable        = 1'b0;
      #1;
      total++;
      if (!found || busy !== 1'b0 || servo_angle !== 8'd0 || sweep_dir !== 1'b1) begin
         bad++;
         $display("FAIL reset_wait_async: got busy=%b angle=%0d dir=%b want 0 0 1",
                  busy, servo_angle, sweep_dir);
      end
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      meas_done     = 1'b1;
      meas_dist     = 10'd55;
      @(negedge clk_clk);
      meas_done = 1'b0;
      quiet = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (sample_valid !== 1'b0 || meas_start !== 1'b0 || busy !== 1'b0 ||
             servo_angle !== 8'd0)
            quiet = 1'b0;
         @(negedge clk_clk);
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL reset_wait_quiet: got v=%b start=%b busy=%b angle=%0d want 0 0 0 0",
                  sample_valid, meas_start, busy, servo_angle);
      end
   endtask

   task automatic test_disable;
      bit found;
      bit idle;
      enable = 1'b1;
      @(negedge clk_clk);
      @(negedge clk_clk);
      enable    = 1'b0;
      meas_done = 1'b1;
      meas_dist = 10'd9;
      @(negedge clk_clk);
      meas_done = 1'b0;
      wait_meas_start(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL disable_start: got no meas_start want one");
      end
      @(negedge clk_clk);
      meas_done = 1'b1;
      meas_dist = 10'd300;
      @(negedge clk_clk);
      meas_done = 1'b0;
      total++;
      if (sample_valid !== 1'b1 || sample_dist !== 10'd300 || sample_angle !== 8'd0) begin
         bad++;
         $display("FAIL disable_sample: got v=%b d=%0d a=%0d want 1 300 0",
                  sample_valid, sample_dist, sample_angle);
      end
      @(negedge clk_clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL disable_step_busy: got %b want 1", busy);
      end
      @(negedge clk_clk);
      total++;
      if (busy !== 1'b0 || servo_angle !== 8'd2 || sweep_dir !== 1'b1) begin
         bad++;
         $display("FAIL disable_idle: got busy=%b angle=%0d dir=%b want 0 2 1",
                  busy, servo_angle, sweep_dir);
      end
      idle = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_clk);
         if (busy !== 1'b0 || meas_start !== 1'b0 || servo_angle !== 8'd2)
            idle = 1'b0;
      end
      total++;
      if (!idle) begin
         bad++;
         $display("FAIL disable_hold: got busy=%b start=%b angle=%0d want 0 0 2",
                  busy, meas_start, servo_angle);
      end
   endtask

   initial begin
      test_reset();
      test_start_latency();
      test_capture();
      test_timeout();
      test_backpressure();
      test_sweep();
      test_reset_mid_wait();
      test_disable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
